// File: rtl/spike_tx_pkg.sv
// Shared definitions for the spike address transmitter: default address width,
// the idle address marker and the FSM state encoding.
package spike_tx_pkg;

  localparam int unsigned ADDR_BITS = 12;

  // All-ones address never maps to a synapse, so it marks "no spike on the bus".
  localparam logic [ADDR_BITS-1:0] IDLE_ADDR = '1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEmit  = 2'd1,
    StClear = 2'd2,
    StDone  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/spike_address_tx_if.sv
// Bus between the spike source / MAC array and the address transmitter.
// master: the transmitter side; slave: the environment driving spikes and ready.
interface spike_address_tx_if #(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned ADDR_BITS   = spike_tx_pkg::ADDR_BITS
);

  logic [NUM_NEURONS-1:0] spikes_in;
  logic                   spikes_valid;
  logic                   addr_ready;
  logic [ADDR_BITS-1:0]   source_address;
  logic                   address_valid;
  logic                   clear;
  logic                   done;
  logic                   busy;
  logic                   overflow;

  modport master (
    input  spikes_in, spikes_valid, addr_ready,
    output source_address, address_valid, clear, done, busy, overflow
  );

  modport slave (
    output spikes_in, spikes_valid, addr_ready,
    input  source_address, address_valid, clear, done, busy, overflow
  );

endinterface

// File: rtl/spike_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit and a flag
// telling whether any bit is set at all.
module spike_prio_enc #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]    vec,
  output logic [IDX_BITS-1:0] idx,
  output logic                any
);

  // Scan from the top so the lowest set bit makes the final assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_BITS'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_address_tx.sv
// Spike address transmitter: latches a fired-neuron vector and serialises it as
// one source address per accepted cycle (lowest neuron first), then issues a
// clear pulse and a done pulse. All outputs are registered.
// Optional feature macro: SPIKE_TX_PENDING_BUF_EN adds a one-deep buffer for a
// vector strobed while busy; without it such vectors are dropped.
module spike_address_tx #(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned ADDR_BITS   = spike_tx_pkg::ADDR_BITS,
  parameter int unsigned BASE_ADDR   = 13
) (
  input logic                clock,
  input logic                set,
  spike_address_tx_if.master bus
);

  import spike_tx_pkg::*;

  localparam int unsigned          IdxBits  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [ADDR_BITS-1:0] IdleAddr = '1;

  // The highest neuron address must stay below the idle marker.
  if (64'(BASE_ADDR) + 64'(NUM_NEURONS) - 64'd1 >= (64'd1 << ADDR_BITS) - 64'd1)
  begin : g_param_check
    $error("spike_address_tx: BASE_ADDR + NUM_NEURONS - 1 must be below IDLE_ADDR");
  end

  tx_state_e              state_q, state_d;
  logic [NUM_NEURONS-1:0] vec_q, vec_d;
  logic [NUM_NEURONS-1:0] load_vec;
  logic                   load;
  logic                   strobe_taken;
  logic                   ovf_q, ovf_d;
  logic [IdxBits-1:0]     low_idx;
  logic                   low_any;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   clear_q, clear_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
`ifdef SPIKE_TX_PENDING_BUF_EN
  logic [NUM_NEURONS-1:0] pend_q, pend_d;
  logic                   pend_full_q, pend_full_d;
`endif

  // Working-vector, pending-buffer and overflow next-state.
  always_comb begin
    vec_d        = vec_q;
    load         = 1'b0;
    load_vec     = bus.spikes_in;
    strobe_taken = 1'b0;
    ovf_d        = ovf_q;
`ifdef SPIKE_TX_PENDING_BUF_EN
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef SPIKE_TX_PENDING_BUF_EN
        if (pend_full_q) begin
          load        = 1'b1;
          load_vec    = pend_q;
          pend_full_d = 1'b0;
        end else begin
          load         = bus.spikes_valid;
          strobe_taken = bus.spikes_valid;
        end
`else
        load         = bus.spikes_valid;
        strobe_taken = bus.spikes_valid;
`endif
      end
      // address_valid is always high in EMIT, so ready alone marks a transfer;
      // v & (v - 1) drops the lowest set bit, i.e. the address just accepted.
      StEmit: begin
        if (bus.addr_ready) begin
          vec_d = vec_q & (vec_q - NUM_NEURONS'(1));
        end
      end
      StDone: begin
`ifdef SPIKE_TX_PENDING_BUF_EN
        // Chain straight into the buffered vector without an IDLE cycle.
        if (pend_full_q) begin
          load        = 1'b1;
          load_vec    = pend_q;
          pend_full_d = 1'b0;
        end
`endif
      end
      default: ;
    endcase

    if (load) begin
      vec_d = load_vec;
    end

    // A strobe not consumed directly is buffered (if possible) or dropped.
    if (bus.spikes_valid && !strobe_taken) begin
`ifdef SPIKE_TX_PENDING_BUF_EN
      if (!pend_full_d) begin
        pend_d      = bus.spikes_in;
        pend_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
`else
      ovf_d = 1'b1;
`endif
    end
  end

  spike_prio_enc #(
    .WIDTH    (NUM_NEURONS),
    .IDX_BITS (IdxBits)
  ) u_prio_enc (
    .vec (vec_d),
    .idx (low_idx),
    .any (low_any)
  );

  // FSM next-state and registered-output next values, derived from the next vector.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = low_any ? StEmit : StClear;
      StEmit:  if (!low_any) state_d = StClear;
      StClear: state_d = StDone;
      StDone:  state_d = load ? (low_any ? StEmit : StClear) : StIdle;
      default: state_d = StIdle;
    endcase

    valid_d = (state_d == StEmit);
    addr_d  = valid_d ? ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(low_idx) : IdleAddr;
    clear_d = (state_d == StClear);
    done_d  = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (set) begin
      state_q     <= StIdle;
      vec_q       <= '0;
      ovf_q       <= 1'b0;
      addr_q      <= IdleAddr;
      valid_q     <= 1'b0;
      clear_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPIKE_TX_PENDING_BUF_EN
      pend_q      <= '0;
      pend_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      ovf_q       <= ovf_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      clear_q     <= clear_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef SPIKE_TX_PENDING_BUF_EN
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
`endif
    end
  end

  assign bus.source_address = addr_q;
  assign bus.address_valid  = valid_q;
  assign bus.clear          = clear_q;
  assign bus.done           = done_q;
  assign bus.busy           = busy_q;
  assign bus.overflow       = ovf_q;

endmodule

// File: tb/tb_spike_address_tx.sv
// Bench for spike_address_tx (NUM_NEURONS=5, BASE_ADDR=13): directed literal
// scenarios plus randomized traffic checked every cycle against a token-queue model.
module tb_spike_address_tx;

  localparam int unsigned N    = 5;
  localparam int unsigned AW   = 12;
  localparam int unsigned BASE = 13;

  logic clock = 1'b0;
  logic set;

  spike_address_tx_if #(.NUM_NEURONS(N), .ADDR_BITS(AW)) bus ();

  spike_address_tx #(
    .NUM_NEURONS (N),
    .ADDR_BITS   (AW),
    .BASE_ADDR   (BASE)
  ) dut (
    .clock (clock),
    .set   (set),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the current job is a queue of output tokens. Address tokens (>=0)
  // leave only when accepted; -1 (clear) and -2 (done) each last one cycle.
  int       tok[$];
  logic [N-1:0] pend;
  bit       pend_full;
  bit       m_ovf;
  bit       started;

  function automatic void start_job(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) tok.push_back(int'(BASE) + i);
    end
    tok.push_back(-1);
    tok.push_back(-2);
  endfunction

  // Packed view: {address, valid, clear, done, busy, overflow}.
  function automatic logic [AW+4:0] model_out();
    logic [AW-1:0] a;
    logic v, c, d, b;
    b = (tok.size() > 0);
    v = b && (tok[0] >= 0);
    c = b && (tok[0] == -1);
    d = b && (tok[0] == -2);
    a = v ? AW'(tok[0]) : '1;
    return {a, v, c, d, b, m_ovf};
  endfunction

  function automatic logic [AW+4:0] dut_out();
    return {bus.source_address, bus.address_valid, bus.clear, bus.done, bus.busy,
            bus.overflow};
  endfunction

  always @(posedge clock) begin : model_step
    bit was_busy;
    bit ending;
    bit from_pend;
    if (set) begin
      tok.delete();
      pend_full = 1'b0;
      m_ovf     = 1'b0;
      started   = 1'b1;
    end else if (started) begin
      was_busy  = (tok.size() > 0);
      ending    = was_busy && (tok[0] == -2);
      from_pend = 1'b0;
      if (was_busy) begin
        if (tok[0] >= 0) begin
          if (bus.addr_ready) void'(tok.pop_front());
        end else begin
          void'(tok.pop_front());
        end
      end
`ifdef SPIKE_TX_PENDING_BUF_EN
      if ((!was_busy || ending) && pend_full) begin
        start_job(pend);
        pend_full = 1'b0;
        from_pend = 1'b1;
      end
`endif
      if (bus.spikes_valid) begin
        if (!was_busy && !from_pend) begin
          start_job(bus.spikes_in);
        end else begin
`ifdef SPIKE_TX_PENDING_BUF_EN
          if (!pend_full) begin
            pend      = bus.spikes_in;
            pend_full = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
`else
          m_ovf = 1'b1;
`endif
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t got=%h required=%h", $time, dut_out(), model_out());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  localparam logic [AW+4:0] ResetVec = {12'hFFF, 5'b00000};

  int seen[$];

  initial begin
    set              = 1'b1;
    bus.spikes_valid = 1'b0;
    bus.spikes_in    = '0;
    bus.addr_ready   = 1'b1;
    tick();
    tick();
    chk("reset_state", 32'(dut_out()), 32'(ResetVec));
    set = 1'b0;
    tick();

    // 10101 with continuous ready.
    bus.spikes_in = 5'b10101; bus.spikes_valid = 1'b1;
    tick(); bus.spikes_valid = 1'b0;
    chk("a_n1_addr13", 32'(dut_out()), 32'({12'd13, 5'b10010}));
    tick(); chk("a_n2_addr15", 32'(dut_out()), 32'({12'd15, 5'b10010}));
    tick(); chk("a_n3_addr17", 32'(dut_out()), 32'({12'd17, 5'b10010}));
    tick(); chk("a_n4_clear", 32'(dut_out()), 32'({12'hFFF, 5'b01010}));
    tick(); chk("a_n5_done", 32'(dut_out()), 32'({12'hFFF, 5'b00110}));
    tick(); chk("a_n6_idle", 32'(dut_out()), 32'(ResetVec));

    // 00011 with back-pressure for three cycles.
    bus.spikes_in = 5'b00011; bus.spikes_valid = 1'b1; bus.addr_ready = 1'b0;
    tick(); bus.spikes_valid = 1'b0;
    chk("b_n1_hold13", 32'(dut_out()), 32'({12'd13, 5'b10010}));
    tick(); chk("b_n2_hold13", 32'(dut_out()), 32'({12'd13, 5'b10010}));
    tick(); chk("b_n3_hold13", 32'(dut_out()), 32'({12'd13, 5'b10010}));
    tick(); bus.addr_ready = 1'b1;
    chk("b_n4_accept13", 32'(dut_out()), 32'({12'd13, 5'b10010}));
    tick(); chk("b_n5_addr14", 32'(dut_out()), 32'({12'd14, 5'b10010}));
    tick(); chk("b_n6_clear", 32'(dut_out()), 32'({12'hFFF, 5'b01010}));
    tick(); tick();

    // Empty vector goes straight to clear/done.
    bus.spikes_in = 5'b00000; bus.spikes_valid = 1'b1;
    tick(); bus.spikes_valid = 1'b0;
    chk("c_n1_clear", 32'(dut_out()), 32'({12'hFFF, 5'b01010}));
    tick(); chk("c_n2_done", 32'(dut_out()), 32'({12'hFFF, 5'b00110}));
    tick(); chk("c_n3_idle", 32'(dut_out()), 32'(ResetVec));

    // Back-to-back strobes: buffered and/or dropped.
    bus.spikes_in = 5'b00001; bus.spikes_valid = 1'b1;
    tick(); if (bus.address_valid && bus.addr_ready) seen.push_back(int'(bus.source_address));
    bus.spikes_in = 5'b00010;
    tick(); if (bus.address_valid && bus.addr_ready) seen.push_back(int'(bus.source_address));
    bus.spikes_in = 5'b00100;
    tick(); bus.spikes_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.address_valid && bus.addr_ready) seen.push_back(int'(bus.source_address));
      tick();
    end
`ifdef SPIKE_TX_PENDING_BUF_EN
    chk("d_addr_count", 32'(seen.size()), 32'd2);
    chk("d_second_addr", 32'(seen[1]), 32'd14);
`else
    chk("d_addr_count", 32'(seen.size()), 32'd1);
`endif
    chk("d_first_addr", 32'(seen[0]), 32'd13);
    chk("d_overflow", 32'(bus.overflow), 32'd1);

    // Reset in the middle of an emission.
    bus.spikes_in = 5'b11111; bus.spikes_valid = 1'b1;
    tick(); bus.spikes_valid = 1'b0;
    chk("e_n1_addr13", 32'(bus.source_address), 32'd13);
    tick(); set = 1'b1;
    tick(); set = 1'b0;
    chk("e_n3_reset", 32'(dut_out()), 32'(ResetVec));
    tick(); chk("e_n4_no_clear", 32'(dut_out()), 32'(ResetVec));
    bus.spikes_valid = 1'b1;
    tick(); bus.spikes_valid = 1'b0;
    chk("e_restart13", 32'(dut_out()), 32'({12'd13, 5'b10010}));
    for (int i = 0; i < 8; i++) tick();

    // Randomized traffic, checked by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      set              = ($urandom_range(0, 99) == 0);
      bus.spikes_valid = ($urandom_range(0, 3) == 0);
      bus.spikes_in    = N'($urandom_range(0, 31));
      bus.addr_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    set = 1'b0; bus.spikes_valid = 1'b0; bus.addr_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_address_tx.md
SPIKE_ADDRESS_TX -- requirements
Module: spike_address_tx

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 10: number of local neurons whose spikes are transmitted.
REQ-002 SHALL have parameter ADDR_BITS, default 12: width of the source-address bus.
REQ-003 SHALL have parameter BASE_ADDR, default 13: source address of neuron index 0.
REQ-004 SHALL have port clock, input, 1: single clock; all logic is on the rising edge.
REQ-005 SHALL have port set, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port spikes_in, input, NUM_NEURONS: fired-neuron vector; bit i = neuron i spiked.
REQ-007 SHALL have port spikes_valid, input, 1: single-cycle strobe that qualifies spikes_in.
REQ-008 SHALL have port addr_ready, input, 1: downstream MAC bus accepts the current address.
REQ-009 SHALL have port source_address, output, ADDR_BITS: address of the spiking neuron, or IDLE_ADDR.
REQ-010 SHALL have port address_valid, output, 1: source_address carries a spike.
REQ-011 SHALL have port clear, output, 1: one-cycle end-of-timestep pulse to the MAC units.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after clear.
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-014 SHALL have port overflow, output, 1: sticky flag, set when a spike vector is dropped.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, EMIT, CLEAR and DONE.
REQ-016 In IDLE, when spikes_valid is sampled at cycle N, the vector SHALL be latched; at N+1 the state SHALL be EMIT if the vector is nonzero, otherwise CLEAR.
REQ-017 In EMIT, address_valid SHALL be 1 and source_address SHALL equal BASE_ADDR plus the index of the lowest set bit in the working vector.
REQ-018 A transfer SHALL occur when address_valid and addr_ready are both high; the bit for that transfer SHALL be cleared and the next address SHALL be presented in the following cycle, giving one address per cycle under continuous ready.
REQ-019 While address_valid=1 and addr_ready=0, source_address SHALL hold stable.
REQ-020 After the last bit is transferred, the FSM SHALL spend one cycle in CLEAR with clear=1, then one cycle in DONE with done=1.
REQ-021 When address_valid=0, source_address SHALL be IDLE_ADDR (all ones), a value that matches no synapse.
REQ-022 A spikes_valid strobe while busy=1 SHALL be handled per REQ-027 and REQ-028.
REQ-023 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.
REQ-024 Address arithmetic SHALL be ADDR_BITS unsigned; BASE_ADDR+NUM_NEURONS-1 < IDLE_ADDR is a parameter legality rule, checked by elaboration assertion.

Reset
REQ-025 When set=1, the next edge SHALL put the FSM in IDLE and drive source_address=IDLE_ADDR, address_valid=0, clear=0, done=0, busy=0, overflow=0.
REQ-026 set=1 SHALL empty the working vector and the pending buffer; a reset mid-EMIT SHALL abandon the remaining addresses without issuing a clear pulse.

Configuration
REQ-027 With SPIKE_TX_PENDING_BUF_EN defined: one-deep pending buffer.
- A strobe while busy fills the buffer if it is empty.
- If the buffer is full, the new vector is dropped and overflow is set.
- In DONE with the buffer full, the buffered vector is loaded, so EMIT or CLEAR follows directly with no IDLE cycle.
- A strobe in that same DONE cycle refills the buffer.
REQ-028 Without SPIKE_TX_PENDING_BUF_EN: every strobe while busy=1 is dropped and sets overflow.

Structure
REQ-029 Shared package spike_tx_pkg SHALL hold ADDR_BITS, IDLE_ADDR and the state encoding.
REQ-030 The lowest-set-bit encoder SHALL be sub-module spike_prio_enc (NUM_NEURONS-bit in, index plus any-flag out).

Verification (NUM_NEURONS=5, BASE_ADDR=13)
REQ-031 spikes_in=5'b10101 strobed at N, addr_ready=1 -> source_address 13, 15, 17 at N+1..N+3; clear at N+4; done at N+5; IDLE at N+6.
REQ-032 5'b00011 with addr_ready=0 for cycles N+1..N+3 -> 13 held stable with address_valid=1; 14 presented the cycle after the first accept.
REQ-033 5'b00000 -> no address_valid; clear at N+1; done at N+2; source_address stays 12'hFFF.
REQ-034 Strobe 5'b00001 then 5'b00010 at N+1 and 5'b00100 at N+2 -> with the macro: addresses 13 then 14, overflow=1 (third vector dropped). Without the macro: only 13, overflow=1.
REQ-035 set=1 at N+2 during 5'b11111 -> next cycle all outputs are at reset values, no clear pulse; a fresh strobe afterwards restarts from address 13.
